ssd_scan_arbiter: RTL and testbench

SSD_SCAN_ARBITER -- requirements
Module: ssd_scan_arbiter

---
 rtl/ssd_scan_arbiter_pkg.sv | 30 +++
 rtl/ssd_hex_decode.sv | 13 +
 rtl/ssd_scan_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ssd_scan_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_scan_arbiter_pkg.sv
// Shared types and constants for the two-client seven-segment scan arbiter.
`timescale 1ns/1ps
package ssd_scan_arbiter_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned DATA_W     = NUM_DIGITS * NIB_W;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned SEG7_W     = 7;

  // Display ownership
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  // One frame's worth of display content (nibbles plus decimal points)
  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [NUM_DIGITS-1:0] dp;
  } disp_frame_t;

  // Hex digit to active-low {a,b,c,d,e,f,g} cathodes
  localparam logic [SEG7_W-1:0] HEX_SEG_LUT [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational nibble to active-low seven-segment cathode decoder.
`timescale 1ns/1ps
module ssd_hex_decode
  import ssd_scan_arbiter_pkg::*;
(
  input  logic [NIB_W-1:0]  nibble,
  output logic [SEG7_W-1:0] cathode_c
);

  // Table lookup of the segment pattern
  assign cathode_c = HEX_SEG_LUT[nibble];

endmodule

// File: rtl/ssd_scan_arbiter.sv
// Two-client arbiter for an 8-digit multiplexed seven-segment display.
// Grants change only at frame boundaries; the displayed frame comes from a
// shadow copy taken at the boundary so it is never torn.
`timescale 1ns/1ps
module ssd_scan_arbiter
  import ssd_scan_arbiter_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 18,
  parameter int unsigned HOLD_FRAMES = 64
) (
  input  logic                  ClkPort,
  input  logic                  Reset,
  input  logic                  req_a,
  input  logic [DATA_W-1:0]     data_a,
  input  logic [NUM_DIGITS-1:0] dp_a,
  input  logic                  req_b,
  input  logic [DATA_W-1:0]     data_b,
  input  logic [NUM_DIGITS-1:0] dp_b,
  input  logic                  lzb,
  output logic [NUM_DIGITS-1:0] An,
  output logic [7:0]            Seg,
  output logic                  gnt_a,
  output logic                  gnt_b
);

  localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

  logic [SCAN_DIV-1:0] presc;
  logic                tick;
  logic [IDX_W-1:0]    idx;
  logic                frame_end;
  arb_state_t          state;
  arb_state_t          state_nxt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                hold_sat;
  disp_frame_t         shadow;
  logic [NIB_W-1:0]    nib_c;
  logic [SEG7_W-1:0]   cathode_c;
  logic [IDX_W-1:0]    top_digit;
  logic                digit_on_c;

  assign tick      = &presc;
  assign frame_end = tick && (idx == IDX_W'(NUM_DIGITS - 1));
  assign hold_sat  = (hold_cnt == HOLD_W'(HOLD_FRAMES));

  // Scan prescaler and digit index
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= presc + SCAN_DIV'(1);
      if (tick) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  // Ownership state register
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next ownership, evaluated only at the frame boundary
  always_comb begin
    state_nxt = state;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (req_a) begin
            state_nxt = OWN_A;
          end else if (req_b) begin
            state_nxt = OWN_B;
          end
        end
        OWN_A: begin
          if (!req_a) begin
            state_nxt = req_b ? OWN_B : IDLE;
          end
        end
        OWN_B: begin
          if (!req_b) begin
            state_nxt = req_a ? OWN_A : IDLE;
          end else if (req_a && hold_sat) begin
            state_nxt = OWN_A;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Frames held by the current owner, saturating
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      hold_cnt <= '0;
    end else if (frame_end) begin
      if (state_nxt != state) begin
        hold_cnt <= '0;
      end else if (!hold_sat) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

  // Snapshot of the incoming owner's content at the frame boundary
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      shadow <= '0;
    end else if (frame_end) begin
      case (state_nxt)
        OWN_A:   shadow <= '{data: data_a, dp: dp_a};
        OWN_B:   shadow <= '{data: data_b, dp: dp_b};
        default: shadow <= shadow;
      endcase
    end
  end

  // Highest digit holding a nonzero nibble (0 when all are zero)
  always_comb begin
    top_digit = '0;
    for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
      if (shadow.data[NIB_W*k +: NIB_W] != '0) begin
        top_digit = IDX_W'(k);
      end
    end
  end

  assign nib_c      = shadow.data[{idx, 2'b00} +: NIB_W];
  assign digit_on_c = !lzb || (idx <= top_digit);

  ssd_hex_decode u_hex_decode (
    .nibble    (nib_c),
    .cathode_c (cathode_c)
  );

  // Registered anode/cathode drive and grant decode
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      An    <= 8'hFF;
      Seg   <= 8'hFF;
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
    end else begin
      gnt_a <= (state == OWN_A);
      gnt_b <= (state == OWN_B);
      if ((state == IDLE) || !digit_on_c) begin
        An  <= 8'hFF;
        Seg <= 8'hFF;
      end else begin
        An  <= ~(8'b1 << idx);
        Seg <= {cathode_c, ~shadow.dp[idx]};
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_arbiter.sv
// Scoreboard bench: a frame-level model pushes the expected display for every
// digit slot of the next frame; a monitor pops and compares per slot.
`timescale 1ns/1ps
module tb_ssd_scan_arbiter;

  localparam int unsigned SCAN_DIV    = 2;
  localparam int unsigned HOLD_FRAMES = 2;
  localparam int SLOT_CYC  = 4;
  localparam int FRAME_CYC = 32;

  logic        ClkPort = 1'b0;
  logic        Reset;
  logic        req_a, req_b, lzb;
  logic [31:0] data_a, data_b;
  logic [7:0]  dp_a, dp_b;
  logic [7:0]  An, Seg;
  logic        gnt_a, gnt_b;

  ssd_scan_arbiter #(.SCAN_DIV(SCAN_DIV), .HOLD_FRAMES(HOLD_FRAMES)) dut (
    .ClkPort (ClkPort),
    .Reset   (Reset),
    .req_a   (req_a),
    .data_a  (data_a),
    .dp_a    (dp_a),
    .req_b   (req_b),
    .data_b  (data_b),
    .dp_b    (dp_b),
    .lzb     (lzb),
    .An      (An),
    .Seg     (Seg),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b)
  );

  always #5 ClkPort = ~ClkPort;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Cycles since reset release, counted like the DUT prescaler
  int cyc;
  always @(posedge ClkPort or posedge Reset) begin
    if (Reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int         slot;
    logic [7:0] an;
    logic [7:0] seg;
    logic       ga;
    logic       gb;
  } exp_t;
  exp_t sb[$];

  // Frame-level reference: 0 idle, 1 client A, 2 client B
  int          m_state;
  int          m_hold;
  logic [31:0] m_data;
  logic [7:0]  m_dp;
  int          stim_frame;

  function automatic logic [6:0] ref_hex(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  task automatic push_frame(input int frame);
    exp_t e;
    int   top;
    top = 0;
    for (int k = 1; k < 8; k++) if (m_data[4*k +: 4] != 4'h0) top = k;
    for (int k = 0; k < 8; k++) begin
      e.slot = frame * 8 + k;
      e.ga   = (m_state == 1);
      e.gb   = (m_state == 2);
      if (m_state == 0 || (lzb && k > top)) begin
        e.an  = 8'hFF;
        e.seg = 8'hFF;
      end else begin
        e.an  = ~(8'h01 << k);
        e.seg = {ref_hex(m_data[4*k +: 4]), ~m_dp[k]};
      end
      sb.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int t);
    int guard;
    guard = 0;
    while (cyc != t && guard < 5000) begin
      @(negedge ClkPort);
      guard++;
    end
    if (cyc != t) begin
      $display("FAIL wait_cyc target=%0d got=%0d", t, cyc);
      $fatal(1);
    end
  endtask

  // Drive inputs mid-frame; the model applies them at the next boundary
  task automatic drive_frame(input logic ra, input logic [31:0] da, input logic [7:0] dpa,
                             input logic rb, input logic [31:0] db, input logic [7:0] dpb,
                             input logic lz);
    int nxt;
    wait_cyc(stim_frame * FRAME_CYC + 3 * SLOT_CYC + 2);
    req_a = ra; data_a = da; dp_a = dpa;
    req_b = rb; data_b = db; dp_b = dpb;
    lzb   = lz;
    nxt = m_state;
    case (m_state)
      0: if (ra) nxt = 1; else if (rb) nxt = 2;
      1: if (!ra) nxt = rb ? 2 : 0;
      2: if (!rb) nxt = ra ? 1 : 0;
         else if (ra && m_hold == int'(HOLD_FRAMES)) nxt = 1;
      default: nxt = 0;
    endcase
    if (nxt != m_state) m_hold = 0;
    else if (m_hold < int'(HOLD_FRAMES)) m_hold++;
    if (nxt == 1) begin m_data = da; m_dp = dpa; end
    if (nxt == 2) begin m_data = db; m_dp = dpb; end
    m_state = nxt;
    stim_frame++;
    push_frame(stim_frame);
  endtask

  task automatic model_reset();
    m_state = 0; m_hold = 0; m_data = '0; m_dp = '0;
    stim_frame = 0;
    sb.delete();
    push_frame(0);
  endtask

  // Monitor: compare one scoreboard entry per digit slot, mid-slot
  always @(negedge ClkPort) begin
    int   s;
    exp_t e;
    if (!Reset && (cyc % SLOT_CYC) == 2 && sb.size() > 0) begin
      s = cyc / SLOT_CYC;
      if (sb[0].slot < s) begin
        e = sb.pop_front();
        check("sb_slot_missed", 32'(s), 32'(e.slot));
      end else if (sb[0].slot == s) begin
        e = sb.pop_front();
        check($sformatf("An@slot%0d", s),    32'(An),    32'(e.an));
        check($sformatf("Seg@slot%0d", s),   32'(Seg),   32'(e.seg));
        check($sformatf("gnt_a@slot%0d", s), 32'(gnt_a), 32'(e.ga));
        check($sformatf("gnt_b@slot%0d", s), 32'(gnt_b), 32'(e.gb));
      end
    end
  end

  initial begin
    Reset = 1'b1;
    req_a = 0; req_b = 0; data_a = '0; data_b = '0; dp_a = '0; dp_b = '0; lzb = 1'b1;
    repeat (3) @(negedge ClkPort);
    check("rst_An", 32'(An), 32'hFF);
    check("rst_Seg", 32'(Seg), 32'hFF);
    check("rst_gnt_a", 32'(gnt_a), 32'h0);
    check("rst_gnt_b", 32'(gnt_b), 32'h0);
    model_reset();
    Reset = 1'b0;

    // Idle, then B alone with leading-zero blanking
    drive_frame(0, 32'h0, 8'h00, 0, 32'h0, 8'h00, 1);
    drive_frame(0, 32'h0, 8'h00, 1, 32'h0000_00A5, 8'h00, 1);
    // A requests while B owns: held for the hold count, then A takes over
    drive_frame(1, 32'h0000_1234, 8'h02, 1, 32'h0000_00A5, 8'h00, 1);
    drive_frame(1, 32'h0000_1234, 8'h02, 1, 32'h0000_00A5, 8'h00, 1);
    drive_frame(1, 32'h0000_1234, 8'h02, 1, 32'h0000_00A5, 8'h00, 1);
    // Mid-frame data change shows only from the next frame
    drive_frame(1, 32'h1111_1111, 8'h00, 1, 32'h0000_00A5, 8'h00, 1);
    drive_frame(1, 32'h2222_2222, 8'h00, 1, 32'h0000_00A5, 8'h00, 1);
    // A drops: B takes over immediately; all-zero value shows a single 0 with point
    drive_frame(0, 32'h2222_2222, 8'h00, 1, 32'h0000_0000, 8'h01, 1);
    drive_frame(0, 32'h0, 8'h00, 0, 32'h0, 8'h00, 1);
    drive_frame(1, 32'h8000_0003, 8'h80, 0, 32'h0, 8'h00, 1);
    drive_frame(0, 32'h0, 8'h00, 0, 32'h0, 8'h00, 1);
    // Blanking disabled: every digit shown
    drive_frame(1, 32'h0000_00F0, 8'h00, 0, 32'h0, 8'h00, 0);
    drive_frame(1, 32'h0000_00F0, 8'h00, 0, 32'h0, 8'h00, 0);

    // Reset while digit 4 is on
    wait_cyc(stim_frame * FRAME_CYC + 4 * SLOT_CYC + 2);
    check("pre_rst_An_digit4", 32'(An), 32'hEF);
    Reset = 1'b1;
    #1;
    check("midrst_An", 32'(An), 32'hFF);
    check("midrst_Seg", 32'(Seg), 32'hFF);
    check("midrst_gnt_a", 32'(gnt_a), 32'h0);
    check("midrst_gnt_b", 32'(gnt_b), 32'h0);
    repeat (2) @(negedge ClkPort);
    model_reset();
    Reset = 1'b0;

    // First grant at the first boundary after release, scan from digit 0
    drive_frame(1, 32'h0000_0007, 8'h00, 0, 32'h0, 8'h00, 1);
    drive_frame(0, 32'h0, 8'h00, 0, 32'h0, 8'h00, 1);
    wait_cyc((stim_frame + 1) * FRAME_CYC + 2);
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
